spi_master: RTL

Single-clock SPI master that generates framed command transactions toward the SPI slave / memory subsystem. It accepts one command at a time from a host-side valid/ready port, serialises a 10-bit frame (2-bit opcode + 8-bit payload) onto MOSI under SS_n, and for read-data commands captures the 8-bit reply from MISO and returns it on a one-cycle response strobe. It sits directly upstream of the slave: its MOSI/SS_n drive the slave's inputs and its MISO input is the slave's output, all on the shared system clock (no separate SCK).

---
 rtl/spi_master.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master: single-clock framed SPI command master.
// Sends a 10-bit {opcode, payload} frame under SS_n. For read-data frames it
// also waits out the slave turnaround and then captures an 8-bit reply from MISO.
module spi_master #(
    parameter int LEAD_CYCLES = 1,
    parameter int TURN_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       done,
    output logic       busy,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS_n
);

    localparam logic [3:0] LEAD_LAST  = 4'(LEAD_CYCLES - 1);
    localparam logic [3:0] SHIFT_LAST = 4'd9;
    localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] RECV_LAST  = 4'd7;
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TURN,
        ST_RECV,
        ST_GAP
    } state_t;

    state_t     r_state, w_state_nx;
    logic [3:0] r_cnt, w_cnt_nx;
    logic [9:0] r_frame, w_frame_nx;
    logic       r_rd, w_rd_nx;
    logic [7:0] r_rx;
    logic       r_ss_n, r_mosi, r_done, r_rsp_valid;
    logic [7:0] r_rsp_data;
    logic       w_ready, w_accept;
    logic       w_ss_n_nx, w_mosi_nx, w_done_nx, w_rsp_valid_nx;

    // Next-state, counter and frame-latch logic.
    // The registered outputs are derived from the next state, so each pin
    // changes on the same edge that enters the state it belongs to.
    // A command is also accepted in the final GAP cycle. This lets a held
    // cmd_valid produce frames separated by exactly GAP_CYCLES SS_n-high cycles.
    always_comb begin
        w_ready    = (r_state == ST_IDLE) || ((r_state == ST_GAP) && (r_cnt == GAP_LAST));
        w_accept   = cmd_valid && w_ready;
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 4'd1;
        w_frame_nx = r_frame;
        w_rd_nx    = r_rd;
        if (w_accept) begin
            w_frame_nx = {cmd_op, cmd_data};
            w_rd_nx    = (cmd_op == 2'b11);
        end
        case (r_state)
            ST_IDLE: begin
                w_cnt_nx = '0;
                if (w_accept) w_state_nx = ST_LEAD;
            end
            ST_LEAD: if (r_cnt == LEAD_LAST) begin
                w_state_nx = ST_SHIFT;
                w_cnt_nx   = '0;
            end
            ST_SHIFT: if (r_cnt == SHIFT_LAST) begin
                w_state_nx = r_rd ? ST_TURN : ST_GAP;
                w_cnt_nx   = '0;
            end
            ST_TURN: if (r_cnt == TURN_LAST) begin
                w_state_nx = ST_RECV;
                w_cnt_nx   = '0;
            end
            ST_RECV: if (r_cnt == RECV_LAST) begin
                w_state_nx = ST_GAP;
                w_cnt_nx   = '0;
            end
            ST_GAP: if (r_cnt == GAP_LAST) begin
                w_state_nx = w_accept ? ST_LEAD : ST_IDLE;
                w_cnt_nx   = '0;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase

        w_ss_n_nx = (w_state_nx == ST_IDLE) || (w_state_nx == ST_GAP);
        w_mosi_nx = 1'b0;
        if (w_state_nx == ST_LEAD)
            w_mosi_nx = w_frame_nx[9];
        else if (w_state_nx == ST_SHIFT)
            w_mosi_nx = w_frame_nx[4'd9 - w_cnt_nx];
        w_done_nx      = (w_state_nx == ST_GAP) && (r_state != ST_GAP);
        w_rsp_valid_nx = w_done_nx && r_rd;
    end

    // State register, cycle counter and latched command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_frame <= '0;
            r_rd    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_frame <= w_frame_nx;
            r_rd    <= w_rd_nx;
        end
    end

    // Registered pins, MISO shift-in and reply capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_done      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rx        <= '0;
        end else begin
            r_ss_n      <= w_ss_n_nx;
            r_mosi      <= w_mosi_nx;
            r_done      <= w_done_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            if (r_state == ST_RECV) begin
                r_rx <= {r_rx[6:0], MISO};
                if (r_cnt == RECV_LAST) r_rsp_data <= {r_rx[6:0], MISO};
            end
        end
    end

    assign cmd_ready = w_ready;
    assign busy      = !w_ready;
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;
    assign done      = r_done;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule
